idex_operand_stage: RTL and testbench

//  ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU.

---
 rtl/idex_operand_stage.sv | 190 +++++++++++++++++++
 tb/tb_idex_operand_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ---------------------------------------------------------------------------
// idex_operand_stage
//
// ID/EX pipeline register and operand-select stage feeding the ALU.
// Latches one decoded instruction, resolves its rs/rt operands against the
// EX/MEM and MEM/WB producers, picks immediate vs rt for operand B, detects
// load-use hazards (inserting a bubble) and supports valid/ready stalls and
// flushes.
//
// Parameters
//   DATA_W  operand/result width
//   REG_AW  register index width (register 0 is hard-wired zero)
//   OP_W    ALU opcode width
//   FWD_EN  1 = forwarding muxes present, 0 = operands from latched values
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   flush                            kill this stage and the offered word
//   id_valid / id_ready              decode handshake
//   id_rs_data, id_rt_data, id_imm   operand values from decode
//   id_rs, id_rt, id_rd              register indices
//   id_uses_rt, id_alu_src, id_alu_op, id_reg_write,
//   id_mem_read, id_mem_write        decoded controls
//   exm_reg_write, exm_rd, exm_result   EX/MEM forwarding source
//   wb_reg_write, wb_rd, wb_data        MEM/WB forwarding source
//   ex_valid / ex_ready              downstream handshake
//   alu_a, alu_b, alu_op             ALU operands and opcode
//   ex_store_data                    forwarded rt for stores
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write   latched controls
//   load_use                         combinational load-use hazard flag
// ---------------------------------------------------------------------------
module idex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 4,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic              id_alu_src,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,

    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              load_use
);

    // Latched instruction state
    logic              valid_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic [OP_W-1:0]   op_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;

    // Forwarded operand values
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    logic advance;
    logic load_word;

    // A load in this stage whose destination is read by the offered word
    // cannot be satisfied by forwarding; the word must wait one cycle.
    always_comb begin
        load_use = 1'b0;
        if (valid_q && mem_read_q && (rd_q != '0) && id_valid) begin
            if ((id_rs == rd_q) || (id_uses_rt && (id_rt == rd_q)))
                load_use = 1'b1;
        end
    end

    // The stage can take a new word whenever it is empty or its current
    // word is being consumed; a flush always drains the offered word.
    assign advance   = !valid_q || ex_ready;
    assign load_word = id_valid && !load_use;
    assign id_ready  = flush || (!load_use && advance);

    // Operand forwarding: EX/MEM is the younger producer and wins over WB.
    // Register 0 is never forwarded since it always reads as zero.
    generate
        if (FWD_EN != 0) begin : g_fwd
            always_comb begin
                fwd_rs = rs_data_q;
                if (exm_reg_write && (exm_rd == rs_q) && (rs_q != '0))
                    fwd_rs = exm_result;
                else if (wb_reg_write && (wb_rd == rs_q) && (rs_q != '0))
                    fwd_rs = wb_data;
            end

            always_comb begin
                fwd_rt = rt_data_q;
                if (exm_reg_write && (exm_rd == rt_q) && (rt_q != '0))
                    fwd_rt = exm_result;
                else if (wb_reg_write && (wb_rd == rt_q) && (rt_q != '0))
                    fwd_rt = wb_data;
            end
        end else begin : g_nofwd
            assign fwd_rs = rs_data_q;
            assign fwd_rt = rt_data_q;
        end
    endgenerate

    // Pipeline register. While held, the operand data registers absorb any
    // forwarded value so a producer that retires during the stall is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            op_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= load_word;
            if (load_word) begin
                rs_q        <= id_rs;
                rt_q        <= id_rt;
                rd_q        <= id_rd;
                rs_data_q   <= id_rs_data;
                rt_data_q   <= id_rt_data;
                imm_q       <= id_imm;
                alu_src_q   <= id_alu_src;
                op_q        <= id_alu_op;
                reg_write_q <= id_reg_write;
                mem_read_q  <= id_mem_read;
                mem_write_q <= id_mem_write;
            end
        end else if (FWD_EN != 0) begin
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end
    end

    // Output drive; side-effecting controls are masked when nothing valid
    // sits in the stage so a bubble can never write state downstream.
    assign ex_valid      = valid_q;
    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign alu_op        = op_q;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_mem_read   = valid_q & mem_read_q;
    assign ex_mem_write  = valid_q & mem_write_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_operand_stage
//
// Directed testbench for idex_operand_stage: reset, plain pass-through,
// immediate select, forwarding priority, load-use bubble, stall refresh and
// flush. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_idex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_uses_rt;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        load_use;

    int checks = 0;
    int passes = 0;

    idex_operand_stage #(
        .DATA_W(32), .REG_AW(5), .OP_W(4), .FWD_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use(load_use)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and keep score
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drive one decoded word onto the ID side
    task automatic applyStimulus(input logic valid, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] rsd, input logic [31:0] rtd,
                                 input logic [31:0] imm, input logic uses_rt,
                                 input logic src, input logic [3:0] op,
                                 input logic regw, input logic memr,
                                 input logic memw);
        id_valid     = valid;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm       = imm;
        id_uses_rt   = uses_rt;
        id_alu_src   = src;
        id_alu_op    = op;
        id_reg_write = regw;
        id_mem_read  = memr;
        id_mem_write = memw;
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 32'h9, 1, 0, 4'b0010, 1, 1, 1);

        // Reset held two cycles with a word offered
        tick(); tick();
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_alu_op", {28'd0, alu_op}, 32'd0);
        checkOutput("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        checkOutput("rst_ctrls", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        rst = 1'b0;

        // Plain pass-through
        applyStimulus(1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h100, 1, 0, 4'b0010, 1, 0, 0);
        #1 checkOutput("pass_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        checkOutput("pass_ex_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("pass_alu_a", alu_a, 32'd5);
        checkOutput("pass_alu_b", alu_b, 32'd7);
        checkOutput("pass_alu_op", {28'd0, alu_op}, 32'h2);
        checkOutput("pass_ex_rd", {27'd0, ex_rd}, 32'd5);
        checkOutput("pass_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // Immediate select for B, store data still rt
        applyStimulus(1, 5'd1, 5'd2, 5'd6, 32'd9, 32'd3, 32'hFFFF_FFF0, 0, 1, 4'b0000, 0, 0, 1);
        tick();
        checkOutput("imm_alu_b", alu_b, 32'hFFFF_FFF0);
        checkOutput("imm_store_data", ex_store_data, 32'd3);
        checkOutput("imm_mem_write", {31'd0, ex_mem_write}, 32'd1);

        // Forwarding priority on rs=3
        applyStimulus(1, 5'd3, 5'd0, 5'd7, 32'h1, 32'h2, 32'h0, 1, 0, 4'b0110, 1, 0, 0);
        tick();
        exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'h10;
        wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'h20;
        #1 checkOutput("fwd_exm_prio", alu_a, 32'h10);
        exm_reg_write = 0;
        #1 checkOutput("fwd_wb", alu_a, 32'h20);
        wb_reg_write = 0;
        #1 checkOutput("fwd_none", alu_a, 32'h1);

        // Register 0 is never forwarded
        exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'hFF;
        applyStimulus(1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h2, 32'h0, 1, 0, 4'b0111, 1, 0, 0);
        tick();
        checkOutput("r0_alu_a", alu_a, 32'h0);
        checkOutput("r0_alu_b", alu_b, 32'h2);
        exm_reg_write = 0;

        // Load-use: lw to r4, then a reader of r4
        applyStimulus(1, 5'd1, 5'd8, 5'd4, 32'h100, 32'h0, 32'd4, 0, 1, 4'b0010, 1, 1, 0);
        tick();
        checkOutput("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
        checkOutput("lw_alu_b", alu_b, 32'd4);
        applyStimulus(1, 5'd4, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'h0, 1, 0, 4'b0001, 1, 0, 0);
        #1 checkOutput("lu_flag", {31'd0, load_use}, 32'd1);
        checkOutput("lu_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        checkOutput("lu_bubble", {31'd0, ex_valid}, 32'd0);
        checkOutput("lu_bubble_rd", {31'd0, ex_mem_read}, 32'd0);
        checkOutput("lu_ready_again", {31'd0, id_ready}, 32'd1);
        tick();
        checkOutput("lu_accept_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("lu_accept_a", alu_a, 32'hAA);
        checkOutput("lu_accept_op", {28'd0, alu_op}, 32'h1);

        // Stall with a WB producer pulsed in the first stall cycle only
        applyStimulus(1, 5'd1, 5'd6, 5'd10, 32'h11, 32'h22, 32'h0, 1, 0, 4'b0010, 1, 0, 0);
        tick();
        id_valid = 0; ex_ready = 0;
        wb_reg_write = 1; wb_rd = 5'd6; wb_data = 32'h55;
        #1 checkOutput("stall_fwd_b", alu_b, 32'h55);
        checkOutput("stall_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        wb_reg_write = 0;
        #1 checkOutput("stall_refresh_b", alu_b, 32'h55);
        tick(); tick();
        ex_ready = 1;
        #1 checkOutput("stall_release_b", alu_b, 32'h55);
        checkOutput("stall_release_a", alu_a, 32'h11);
        checkOutput("stall_valid", {31'd0, ex_valid}, 32'd1);
        tick();
        checkOutput("drain_valid", {31'd0, ex_valid}, 32'd0);

        // Flush while holding a valid word with another offered
        applyStimulus(1, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'h0, 1, 0, 4'b0010, 1, 0, 0);
        tick();
        ex_ready = 0; flush = 1;
        applyStimulus(1, 5'd3, 5'd4, 5'd13, 32'h3, 32'h4, 32'h0, 1, 0, 4'b0001, 1, 0, 0);
        #1 checkOutput("flush_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        flush = 0; id_valid = 0; ex_ready = 1;
        #1 checkOutput("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
        tick();
        checkOutput("flush_stays_empty", {31'd0, ex_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
